// File: rtl/aux_periph_target.sv
// Aux-bus target: LED, scratch, 64-bit cycle counter and countdown timer
// registers behind a two-stage (request / abort-check) pipeline with tagged
// read return.
module aux_periph_target #(
  parameter logic [31:0] BASE_ADDR = 32'hE000_0000,
  parameter int unsigned LED_WIDTH = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_aux_request,
  input  logic [31:0]          cpu_aux_addr,
  input  logic                 cpu_aux_write,
  input  logic [3:0]           cpu_aux_wstrb,
  input  logic [31:0]          cpu_aux_wdata,
  input  logic                 cpu_aux_abort,
  output logic                 cpu_aux_rvalid,
  output logic [31:0]          cpu_aux_rdata,
  output logic [8:0]           cpu_aux_rtag,
  output logic                 timer_irq,
  output logic [LED_WIDTH-1:0] leds
);

  localparam int unsigned DW  = 32;
  localparam int unsigned TGW = 9;
  localparam int unsigned IXW = 4;
  localparam int unsigned SBW = 4;
  localparam int unsigned CCW = 64;
  localparam int unsigned CTW = 3;

  localparam logic [IXW-1:0] IDX_LEDS    = 4'h0;
  localparam logic [IXW-1:0] IDX_SCRATCH = 4'h1;
  localparam logic [IXW-1:0] IDX_CYC_LO  = 4'h2;
  localparam logic [IXW-1:0] IDX_CYC_HI  = 4'h3;
  localparam logic [IXW-1:0] IDX_TLOAD   = 4'h4;
  localparam logic [IXW-1:0] IDX_TCOUNT  = 4'h5;
  localparam logic [IXW-1:0] IDX_TCTRL   = 4'h6;
  localparam logic [IXW-1:0] IDX_TSTAT   = 4'h7;

  // Byte-lane merge of new data into an old register value
  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [SBW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < int'(SBW); b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic                 r_s1_valid;
  logic                 r_s1_write;
  logic [IXW-1:0]       r_s1_idx;
  logic [SBW-1:0]       r_s1_wstrb;
  logic [DW-1:0]        r_s1_wdata;

  logic [LED_WIDTH-1:0] r_leds;
  logic [DW-1:0]        r_scratch;
  logic [CCW-1:0]       r_cycle;
  logic [DW-1:0]        r_hi_snap;
  logic [DW-1:0]        r_load;
  logic [DW-1:0]        r_count;
  logic [CTW-1:0]       r_ctrl;
  logic                 r_expired;
  logic                 r_irq;

  logic                 r_rvalid;
  logic [DW-1:0]        r_rdata;
  logic [TGW-1:0]       r_rtag;

  logic                 w_hit;
  logic                 w_live;
  logic                 w_wr;
  logic                 w_rd;
  logic [DW-1:0]        w_rd_data;
  logic [DW-1:0]        w_load_new;
  logic [DW-1:0]        w_cnt_nxt;
  logic                 w_exp_nxt;
  logic                 w_unused;

  assign w_hit    = cpu_aux_request & (cpu_aux_addr[31:6] == BASE_ADDR[31:6]);
  assign w_live   = r_s1_valid & ~cpu_aux_abort;
  assign w_wr     = w_live & r_s1_write;
  assign w_rd     = w_live & ~r_s1_write;
  assign w_unused = ^cpu_aux_addr[1:0];

  // Stage 1 capture of window hits; the abort for this slot arrives next cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_write <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_wstrb <= '0;
      r_s1_wdata <= '0;
    end else begin
      r_s1_valid <= w_hit;
      if (w_hit) begin
        r_s1_write <= cpu_aux_write;
        r_s1_idx   <= cpu_aux_addr[5:2];
        r_s1_wstrb <= cpu_aux_wstrb;
        r_s1_wdata <= cpu_aux_wdata;
      end
    end
  end

  // Timer next state: a LOAD write overrides the decrement, expiry beats W1C
  always_comb begin
    w_load_new = f_merge(r_load, r_s1_wdata, r_s1_wstrb);
    w_cnt_nxt  = r_count;
    w_exp_nxt  = r_expired;
    if (r_ctrl[0] && (r_count != '0)) begin
      if (r_count == DW'(1)) begin
        w_cnt_nxt = r_ctrl[1] ? r_load : '0;
      end else begin
        w_cnt_nxt = r_count - DW'(1);
      end
    end
    if (w_wr && (r_s1_idx == IDX_TLOAD)) w_cnt_nxt = w_load_new;
    if (w_wr && (r_s1_idx == IDX_TSTAT) && r_s1_wstrb[0] && r_s1_wdata[0]) w_exp_nxt = 1'b0;
    if (r_ctrl[0] && (r_count == DW'(1))) w_exp_nxt = 1'b1;
  end

  // Register file, cycle counter and timer state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_leds    <= '0;
      r_scratch <= '0;
      r_cycle   <= '0;
      r_hi_snap <= '0;
      r_load    <= '0;
      r_count   <= '0;
      r_ctrl    <= '0;
      r_expired <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_cycle   <= r_cycle + CCW'(1);
      r_count   <= w_cnt_nxt;
      r_expired <= w_exp_nxt;
      r_irq     <= r_expired & r_ctrl[2];
      if (w_wr) begin
        case (r_s1_idx)
          IDX_LEDS:    r_leds    <= LED_WIDTH'(f_merge(DW'(r_leds), r_s1_wdata, r_s1_wstrb));
          IDX_SCRATCH: r_scratch <= f_merge(r_scratch, r_s1_wdata, r_s1_wstrb);
          IDX_TLOAD:   r_load    <= w_load_new;
          IDX_TCTRL:   r_ctrl    <= CTW'(f_merge(DW'(r_ctrl), r_s1_wdata, r_s1_wstrb));
          default:     ;
        endcase
      end
      if (w_rd && (r_s1_idx == IDX_CYC_LO)) r_hi_snap <= r_cycle[63:32];
    end
  end

  // Read mux sampled in the abort-check cycle
  always_comb begin
    w_rd_data = '0;
    case (r_s1_idx)
      IDX_LEDS:    w_rd_data = DW'(r_leds);
      IDX_SCRATCH: w_rd_data = r_scratch;
      IDX_CYC_LO:  w_rd_data = r_cycle[31:0];
      IDX_CYC_HI:  w_rd_data = r_hi_snap;
      IDX_TLOAD:   w_rd_data = r_load;
      IDX_TCOUNT:  w_rd_data = r_count;
      IDX_TCTRL:   w_rd_data = DW'(r_ctrl);
      IDX_TSTAT:   w_rd_data = DW'(r_expired);
      default:     w_rd_data = '0;
    endcase
  end

  // Registered read return
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rtag   <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rd_data;
        r_rtag  <= r_s1_wdata[8:0];
      end
    end
  end

  assign cpu_aux_rvalid = r_rvalid;
  assign cpu_aux_rdata  = r_rdata;
  assign cpu_aux_rtag   = r_rtag;
  assign timer_irq      = r_irq;
  assign leds           = r_leds;

endmodule

// File: tb/tb_aux_periph_target.sv
// Scoreboard bench for aux_periph_target: expected read returns are queued
// when requests are issued and popped when the DUT returns them.
module tb_aux_periph_target;

  localparam logic [31:0] BASE = 32'hE000_0000;
  localparam int unsigned LW   = 10;

  logic          clock;
  logic          reset;
  logic          cpu_aux_request;
  logic [31:0]   cpu_aux_addr;
  logic          cpu_aux_write;
  logic [3:0]    cpu_aux_wstrb;
  logic [31:0]   cpu_aux_wdata;
  logic          cpu_aux_abort;
  logic          cpu_aux_rvalid;
  logic [31:0]   cpu_aux_rdata;
  logic [8:0]    cpu_aux_rtag;
  logic          timer_irq;
  logic [LW-1:0] leds;

  typedef struct {
    logic [31:0] data;
    logic [8:0]  tag;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rv     = 0;
  int   cyc      = 0;
  logic pend_ab  = 1'b0;

  aux_periph_target #(.BASE_ADDR(BASE), .LED_WIDTH(LW)) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_aux_request (cpu_aux_request),
    .cpu_aux_addr    (cpu_aux_addr),
    .cpu_aux_write   (cpu_aux_write),
    .cpu_aux_wstrb   (cpu_aux_wstrb),
    .cpu_aux_wdata   (cpu_aux_wdata),
    .cpu_aux_abort   (cpu_aux_abort),
    .cpu_aux_rvalid  (cpu_aux_rvalid),
    .cpu_aux_rdata   (cpu_aux_rdata),
    .cpu_aux_rtag    (cpu_aux_rtag),
    .timer_irq       (timer_irq),
    .leds            (leds)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bench cycle count: number of rising edges seen so far
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit f_hit(input logic [31:0] a);
    logic [31:0] b;
    b = BASE;
    return a[31:6] == b[31:6];
  endfunction

  // Read-return monitor
  always @(negedge clock) begin
    exp_t e;
    if (reset && cpu_aux_rvalid) begin
      n_rv++;
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rdata", 64'(cpu_aux_rdata), 64'(e.data));
        chk("rtag", 64'(cpu_aux_rtag), 64'(e.tag));
        chk("rlatency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // One request slot; ab kills this request via the next cycle's abort
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic ab, input logic [31:0] exp_rd);
    cpu_aux_abort   = pend_ab;
    pend_ab         = ab;
    cpu_aux_request = 1'b1;
    cpu_aux_write   = wr;
    cpu_aux_addr    = addr;
    cpu_aux_wstrb   = strb;
    cpu_aux_wdata   = data;
    if (!wr && !ab && f_hit(addr)) sb.push_back('{exp_rd, data[8:0], cyc + 2});
    @(negedge clock);
  endtask

  task automatic wr_reg(input logic [5:0] off, input logic [31:0] data, input logic [3:0] strb,
                        input logic ab);
    issue(1'b1, BASE + 32'(off), data, strb, ab, 32'd0);
  endtask

  task automatic rd_reg(input logic [5:0] off, input logic [8:0] tag, input logic ab,
                        input logic [31:0] exp_rd);
    issue(1'b0, BASE + 32'(off), 32'(tag), 4'h0, ab, exp_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_aux_request = 1'b0;
      cpu_aux_write   = 1'b0;
      cpu_aux_abort   = pend_ab;
      pend_ab         = 1'b0;
      @(negedge clock);
    end
  endtask

  function automatic logic [31:0] f_tcount(input int p, input int k);
    return 32'(5 - ((p - (k + 8)) % 5));
  endfunction

  int k;
  int k2;
  int c0;
  int rv0;
  logic [31:0] frozen;

  initial begin
    reset           = 1'b0;
    cpu_aux_request = 1'b0;
    cpu_aux_addr    = '0;
    cpu_aux_write   = 1'b0;
    cpu_aux_wstrb   = '0;
    cpu_aux_wdata   = '0;
    cpu_aux_abort   = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_rvalid", 64'(cpu_aux_rvalid), 64'd0);
    chk("rst_rdata", 64'(cpu_aux_rdata), 64'd0);
    chk("rst_rtag", 64'(cpu_aux_rtag), 64'd0);
    chk("rst_irq", 64'(timer_irq), 64'd0);
    chk("rst_leds", 64'(leds), 64'd0);
    reset = 1'b1;
    idle(2);

    // LED byte-0 write then tagged read
    wr_reg(6'h00, 32'h0000_03FF, 4'b0001, 1'b0);
    rd_reg(6'h00, 9'h1A5, 1'b0, 32'h0000_00FF);
    idle(3);
    chk("leds_out", 64'(leds), 64'h0FF);

    // Aborted write leaves scratch at 0; aborted read returns nothing
    wr_reg(6'h04, 32'hDEAD_BEEF, 4'hF, 1'b1);
    rd_reg(6'h04, 9'h011, 1'b0, 32'h0);
    rd_reg(6'h04, 9'h012, 1'b1, 32'h0);
    idle(4);
    chk("abort_drained", 64'(sb.size()), 64'd0);

    // Byte merge, unused window, non-hit traffic, abort with empty slot
    wr_reg(6'h04, 32'h1122_3344, 4'hF, 1'b0);
    wr_reg(6'h04, 32'hAABB_CCDD, 4'b1010, 1'b0);
    wr_reg(6'h20, 32'h1234_5678, 4'hF, 1'b0);
    issue(1'b1, BASE + 32'h44, 32'h5555_5555, 4'hF, 1'b0, 32'h0);
    issue(1'b0, 32'hD000_0004, 32'h0AA, 4'h0, 1'b0, 32'h0);
    idle(1);
    pend_ab = 1'b1;
    rd_reg(6'h04, 9'h021, 1'b0, 32'hAA22_CC44);
    rd_reg(6'h20, 9'h022, 1'b0, 32'h0);
    wr_reg(6'h04, 32'h0000_0000, 4'h0, 1'b0);
    rd_reg(6'h04, 9'h023, 1'b0, 32'hAA22_CC44);
    idle(3);

    // Back-to-back reads, second one aborted
    rv0 = n_rv;
    rd_reg(6'h04, 9'd1, 1'b0, 32'hAA22_CC44);
    rd_reg(6'h04, 9'd2, 1'b1, 32'h0);
    rd_reg(6'h04, 9'd3, 1'b0, 32'hAA22_CC44);
    rd_reg(6'h04, 9'd4, 1'b0, 32'hAA22_CC44);
    idle(4);
    chk("b2b_pulses", 64'(n_rv - rv0), 64'd3);

    // Timer with auto-reload and interrupt
    k = cyc;
    wr_reg(6'h10, 32'd5, 4'hF, 1'b0);
    wr_reg(6'h18, 32'd7, 4'hF, 1'b0);
    idle(5);
    rd_reg(6'h14, 9'h031, 1'b0, 32'd5);
    idle(1);
    for (int i = 0; i < 20 && !timer_irq; i++) idle(1);
    chk("irq_time", 64'(cyc), 64'(k + 9));
    chk("irq_set", 64'(timer_irq), 64'd1);
    k2 = cyc;
    frozen = f_tcount(k2 + 2, k);
    wr_reg(6'h18, 32'd4, 4'hF, 1'b0);
    wr_reg(6'h1C, 32'd0, 4'b0001, 1'b0);
    wr_reg(6'h1C, 32'd1, 4'b0000, 1'b0);
    idle(3);
    chk("irq_hold", 64'(timer_irq), 64'd1);
    rd_reg(6'h1C, 9'h032, 1'b0, 32'd1);
    wr_reg(6'h1C, 32'd1, 4'b0001, 1'b0);
    idle(3);
    chk("irq_clear", 64'(timer_irq), 64'd0);
    rd_reg(6'h1C, 9'h033, 1'b0, 32'd0);
    rd_reg(6'h14, 9'h034, 1'b0, frozen);
    rd_reg(6'h18, 9'h035, 1'b0, 32'd4);
    rd_reg(6'h10, 9'h036, 1'b0, 32'd5);
    idle(3);

    // Cycle counter low/high snapshot across the 32-bit boundary
    force dut.r_cycle = 64'h0000_0000_FFFF_FFFE;
    #1;
    release dut.r_cycle;
    rd_reg(6'h08, 9'h041, 1'b0, 32'hFFFF_FFFF);
    rd_reg(6'h0C, 9'h042, 1'b0, 32'h0);
    rd_reg(6'h08, 9'h043, 1'b0, 32'h1);
    rd_reg(6'h0C, 9'h044, 1'b0, 32'h1);
    idle(3);

    // Reset while a read sits in the abort-check stage
    rd_reg(6'h04, 9'h051, 1'b0, 32'h0);
    reset = 1'b0;
    void'(sb.pop_back());
    pend_ab = 1'b0;
    idle(3);
    chk("rst2_leds", 64'(leds), 64'd0);
    chk("rst2_rvalid", 64'(cpu_aux_rvalid), 64'd0);
    reset = 1'b1;
    c0 = cyc;
    idle(2);
    for (int i = 0; i < 8; i++) begin
      rd_reg(6'(i * 4), 9'(9'h060 + i), 1'b0, (i == 2) ? 32'(cyc + 1 - c0) : 32'h0);
    end
    idle(4);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
